// File: rtl/cnn_stage_pkg.sv
// Shared types and arithmetic helpers for the conv -> activation -> max-pool stage.
package cnn_stage_pkg;

    typedef enum logic [1:0] {ACCEPT, MAC, POST, OUT} stage_state_e;
    typedef enum logic {ACT_NONE, ACT_RELU} act_mode_e;

    localparam int SAT_W = 64;

    // Accumulator must hold taps full-precision products plus sign headroom.
    function automatic int acc_width(input int dw, input int taps);
        return 2 * dw + $clog2(taps) + 1;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_dw(input logic signed [SAT_W-1:0] acc,
                                                       input int dw);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (acc > hi) return hi;
        if (acc < lo) return lo;
        return acc;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One output channel: weight/bias storage, MAC accumulator, post-scale, activation,
// saturation and running max-pool register.
module mac_lane
    import cnn_stage_pkg::*;
#(
    parameter int DW   = 16,
    parameter int FRAC = 8,
    parameter int NW   = 3,
    parameter int TW   = 2,
    parameter int IW   = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          w_we,
    input  logic [IW-1:0] w_idx,
    input  logic [DW-1:0] w_data,
    input  logic          mac_en,
    input  logic [TW-1:0] tap,
    input  logic [DW-1:0] x,
    input  logic          post_en,
    input  logic          relu,
    input  logic          pool_first,
    output logic [DW-1:0] pool_next
);

    localparam int ACC_W = acc_width(DW, NW);

    logic signed [DW-1:0]    wgt [NW];
    logic signed [DW-1:0]    bias;
    logic signed [DW-1:0]    pmax;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] scaled;
    logic signed [2*DW-1:0]  prod;
    logic signed [DW-1:0]    res;

    always_comb begin
        prod     = $signed(x) * wgt[tap];
        prod_ext = ACC_W'(prod);
        // Bias is in sample format, so align it to the product's 2*FRAC fraction first.
        sum      = acc + (ACC_W'(bias) <<< FRAC);
        scaled   = sum >>> FRAC;
        if (relu && scaled < 0) scaled = '0;
        res       = DW'(sat_dw(SAT_W'(scaled), DW));
        pool_next = (pool_first || res > pmax) ? res : pmax;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NW; i++) wgt[i] <= '0;
            bias <= '0;
            acc  <= '0;
            pmax <= '0;
        end else begin
            if (w_we) begin
                if (w_idx == IW'(NW)) bias <= w_data;
                else if (w_idx < IW'(NW)) wgt[w_idx] <= w_data;
            end
            if (mac_en) acc <= (tap == '0 ? '0 : acc) + prod_ext;
            if (post_en) pmax <= pool_next;
        end
    end

endmodule

// File: rtl/conv_act_pool_stage.sv
// Streaming 1-D convolution -> activation -> max-pool stage with one MAC lane per output channel.
//   state  | meaning
//   ACCEPT | take a beat into the K-deep window; MAC once the window is full
//   MAC    | C_IN*K cycles, one tap/channel product per lane per cycle
//   POST   | bias, rescale, activation, saturation, fold into pool max
//   OUT    | hold pooled result until downstream takes it
module conv_act_pool_stage
    import cnn_stage_pkg::*;
#(
    parameter  int DW    = 16,
    parameter  int FRAC  = 8,
    parameter  int C_IN  = 1,
    parameter  int C_OUT = 3,
    parameter  int K     = 3,
    parameter  int P     = 2,
    localparam int AW    = $clog2(C_OUT * (C_IN * K + 1))
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [C_IN*DW-1:0]    in_data,
    input  logic                  in_last,
    input  logic                  act_mode,
    input  logic                  w_we,
    input  logic [AW-1:0]         w_addr,
    input  logic [DW-1:0]         w_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [C_OUT*DW-1:0]   out_data,
    output logic                  out_last
);

    localparam int NW = C_IN * K;
    localparam int N  = NW + 1;
    localparam int TW = (NW > 1) ? $clog2(NW) : 1;
    localparam int IW = $clog2(N);
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int CW = (C_IN > 1) ? $clog2(C_IN) : 1;
    localparam int FW = $clog2(K + 1);
    localparam int PW = $clog2(P + 1);

    stage_state_e         state;
    act_mode_e            act_q;
    logic [FW-1:0]        fill;
    logic [PW-1:0]        pcnt;
    logic                 last_q;
    logic [TW-1:0]        tap;
    logic [KW-1:0]        k_cnt;
    logic [CW-1:0]        ci_cnt;
    logic [C_IN*DW-1:0]   win [K];
    logic [DW-1:0]        x_sel;
    logic [C_OUT*DW-1:0]  pool_bus;
    logic                 we_ok;
    logic [31:0]          w_addr32;

    // win[0] is the oldest beat and pairs with tap 0.
    always_comb begin
        x_sel    = win[k_cnt][ci_cnt*DW +: DW];
        we_ok    = w_we && (state == ACCEPT) && (fill == '0);
        w_addr32 = 32'(w_addr);
    end

    for (genvar co = 0; co < C_OUT; co++) begin : g_lane
        logic [31:0] lane_off;
        logic        lane_we;
        // Unsigned wrap makes addresses below this lane's base fail the range test too.
        assign lane_off = w_addr32 - 32'(co * N);
        assign lane_we  = we_ok && (lane_off < 32'(N));

        mac_lane #(.DW(DW), .FRAC(FRAC), .NW(NW), .TW(TW), .IW(IW)) u_lane (
            .clk        (clk),
            .reset      (reset),
            .w_we       (lane_we),
            .w_idx      (lane_off[IW-1:0]),
            .w_data     (w_data),
            .mac_en     (state == MAC),
            .tap        (tap),
            .x          (x_sel),
            .post_en    (state == POST),
            .relu       (act_q == ACT_RELU),
            .pool_first (pcnt == '0),
            .pool_next  (pool_bus[co*DW +: DW])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ACCEPT;
            act_q     <= ACT_NONE;
            in_ready  <= 1'b0;
            fill      <= '0;
            pcnt      <= '0;
            last_q    <= 1'b0;
            tap       <= '0;
            k_cnt     <= '0;
            ci_cnt    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            for (int i = 0; i < K; i++) win[i] <= '0;
        end else begin
            case (state)
                ACCEPT: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        for (int i = 0; i < K - 1; i++) win[i] <= win[i+1];
                        win[K-1] <= in_data;
                        if (fill >= FW'(K - 1)) begin
                            fill     <= FW'(K);
                            state    <= MAC;
                            in_ready <= 1'b0;
                            last_q   <= in_last;
                            act_q    <= act_mode_e'(act_mode);
                            tap      <= '0;
                            k_cnt    <= '0;
                            ci_cnt   <= '0;
                        end else if (in_last) begin
                            fill <= '0;
                            pcnt <= '0;
                        end else begin
                            fill <= fill + FW'(1);
                        end
                    end
                end
                MAC: begin
                    tap <= tap + TW'(1);
                    if (k_cnt == KW'(K - 1)) begin
                        k_cnt <= '0;
                        if (ci_cnt == CW'(C_IN - 1)) begin
                            ci_cnt <= '0;
                            state  <= POST;
                        end else begin
                            ci_cnt <= ci_cnt + CW'(1);
                        end
                    end else begin
                        k_cnt <= k_cnt + KW'(1);
                    end
                end
                POST: begin
                    pcnt <= pcnt + PW'(1);
                    if (pcnt == PW'(P - 1) || last_q) begin
                        state     <= OUT;
                        out_valid <= 1'b1;
                        out_data  <= pool_bus;
                        out_last  <= last_q;
                    end else begin
                        state    <= ACCEPT;
                        in_ready <= 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        pcnt      <= '0;
                        if (last_q) fill <= '0;
                        state    <= ACCEPT;
                        in_ready <= 1'b1;
                    end
                end
                default: state <= ACCEPT;
            endcase
        end
    end

endmodule
